// File: rtl/cpu_operand_stage_if.sv
// -----------------------------------------------------------------------------
// cpu_operand_stage_if
//   Bundle of the fetch / operand / write-back signals between the operand
//   stage, instruction memory and the ALU.
//
//   INSTRUCTION  32  instruction word at the current PC
//   ALURESULT     8  ALU result returned for register write-back
//   PC           32  current program counter (drives instruction memory)
//   DATA1         8  ALU operand 1 (reg[rs1])
//   DATA2         8  ALU operand 2 (after immediate / negate selection)
//   ALUOP         3  ALU select
//
//   master : the operand stage itself (owns PC and the operands)
//   slave  : the surroundings (instruction memory + ALU)
// -----------------------------------------------------------------------------
interface cpu_operand_stage_if;
  logic [31:0] INSTRUCTION;
  logic [7:0]  ALURESULT;
  logic [31:0] PC;
  logic [7:0]  DATA1;
  logic [7:0]  DATA2;
  logic [2:0]  ALUOP;

  modport master (
    input  INSTRUCTION,
    input  ALURESULT,
    output PC,
    output DATA1,
    output DATA2,
    output ALUOP
  );

  modport slave (
    output INSTRUCTION,
    output ALURESULT,
    input  PC,
    input  DATA1,
    input  DATA2,
    input  ALUOP
  );
endinterface

// File: rtl/cpu_operand_stage.sv
// -----------------------------------------------------------------------------
// cpu_operand_stage
//   Front end of the 8-bit single-cycle processor. Holds the program counter
//   and the 8 x 8-bit register file, decodes the 32-bit instruction and
//   presents the two ALU operands plus the ALU select. The ALU result comes
//   back on ALURESULT and is written to rd at the next rising edge, so one
//   instruction retires per cycle.
//
//   CLK    in   system clock, all state changes on the rising edge
//   RESET  in   asynchronous active-high reset (PC and registers to 0)
//   bus    master modport of cpu_operand_stage_if:
//            INSTRUCTION in, ALURESULT in, PC out, DATA1 out, DATA2 out,
//            ALUOP out
//
//   Instruction fields: opcode [31:24], rd [18:16], offset [23:16],
//   rs1 [10:8], rs2 [2:0], imm [7:0].
// -----------------------------------------------------------------------------
module cpu_operand_stage (
  input  logic                  CLK,
  input  logic                  RESET,
  cpu_operand_stage_if.master   bus
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  localparam logic [2:0] ALU_FWD  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] r_pc;
  logic [7:0]  r_regs [8];

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [7:0]  w_opcode;
  logic [2:0]  w_rd;
  logic [7:0]  w_offset;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic [7:0]  w_imm;

  assign w_opcode = bus.INSTRUCTION[31:24];
  assign w_rd     = bus.INSTRUCTION[18:16];
  assign w_offset = bus.INSTRUCTION[23:16];
  assign w_rs1    = bus.INSTRUCTION[10:8];
  assign w_rs2    = bus.INSTRUCTION[2:0];
  assign w_imm    = bus.INSTRUCTION[7:0];

  // ---------------------------------------------------------------------------
  // Register file read ports (combinational, no bypass from the write port)
  // ---------------------------------------------------------------------------
  logic [7:0] w_rs1_val;
  logic [7:0] w_rs2_val;
  logic [7:0] w_rs2_neg;

  assign w_rs1_val = r_regs[w_rs1];
  assign w_rs2_val = r_regs[w_rs2];
  // Two's complement so the ALU's add performs subtraction.
  assign w_rs2_neg = (~w_rs2_val) + 8'd1;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [7:0] w_data2;
  logic [2:0] w_aluop;
  logic       w_wr_en;
  logic       w_take_target;

  always_comb begin
    w_data2       = w_rs2_val;
    w_aluop       = ALU_FWD;
    w_wr_en       = 1'b0;
    w_take_target = 1'b0;
    case (w_opcode)
      OP_LOADI: begin
        w_data2 = w_imm;
        w_wr_en = 1'b1;
      end
      OP_MOV: begin
        w_wr_en = 1'b1;
      end
      OP_ADD: begin
        w_aluop = ALU_ADD;
        w_wr_en = 1'b1;
      end
      OP_SUB: begin
        w_data2 = w_rs2_neg;
        w_aluop = ALU_ADD;
        w_wr_en = 1'b1;
      end
      OP_AND: begin
        w_aluop = ALU_AND;
        w_wr_en = 1'b1;
      end
      OP_OR: begin
        w_aluop = ALU_OR;
        w_wr_en = 1'b1;
      end
      OP_J: begin
        w_take_target = 1'b1;
      end
      OP_BEQ: begin
        // The ALU sees rs1 - rs2, but the branch decision uses the raw
        // register values so it does not depend on the ALU at all.
        w_data2       = w_rs2_neg;
        w_aluop       = ALU_ADD;
        w_take_target = (w_rs1_val == w_rs2_val);
      end
      default: begin
      end
    endcase
  end

  assign bus.DATA1 = w_rs1_val;
  assign bus.DATA2 = w_data2;
  assign bus.ALUOP = w_aluop;
  assign bus.PC    = r_pc;

  // ---------------------------------------------------------------------------
  // Next PC: word offset, sign-extended, relative to PC+4; wraps mod 2^32.
  // ---------------------------------------------------------------------------
  logic [31:0] w_pc_plus4;
  logic [31:0] w_offset_bytes;
  logic [31:0] w_target;
  logic [31:0] w_pc_next;

  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_offset_bytes = {{22{w_offset[7]}}, w_offset, 2'b00};
  assign w_target       = w_pc_plus4 + w_offset_bytes;
  assign w_pc_next      = w_take_target ? w_target : w_pc_plus4;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc <= 32'd0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file write port; one process per register keeps the write
  // decode explicit and lets every register reset asynchronously.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_reg
      logic w_sel;
      assign w_sel = w_wr_en && (w_rd == 3'(gi));

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          r_regs[gi] <= 8'd0;
        end else if (w_sel) begin
          r_regs[gi] <= bus.ALURESULT;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_cpu_operand_stage.sv
`timescale 1ns/1ps
module tb_cpu_operand_stage;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  cpu_operand_stage_if bus ();

  cpu_operand_stage dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  // Architectural model: PC and register array, updated per retired instr.
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc = 32'd0;
  logic [7:0]  m_regs [8] = '{default: 8'h00};

  function automatic void model_out(input logic [31:0] ins,
                                    output logic [7:0] d1,
                                    output logic [7:0] d2,
                                    output logic [2:0] op,
                                    output bit wr,
                                    output logic [31:0] npc);
    int opc;
    int a;
    int b;
    int off;
    opc = int'(ins[31:24]);
    a   = int'(m_regs[ins[10:8]]);
    b   = int'(m_regs[ins[2:0]]);
    off = int'($signed(ins[23:16]));
    d1  = 8'(a);
    d2  = 8'(b);
    op  = 3'd0;
    wr  = (opc <= 5);
    npc = m_pc + 32'd4;
    if (opc == 0) d2 = ins[7:0];
    if (opc == 2 || opc == 3 || opc == 7) op = 3'd1;
    if (opc == 4) op = 3'd2;
    if (opc == 5) op = 3'd3;
    if (opc == 3 || opc == 7) d2 = 8'((256 - b) % 256);
    if (opc == 6 || (opc == 7 && a == b)) npc = m_pc + 32'(4 + 4 * off);
  endfunction

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] op);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return b;
    endcase
  endfunction

  always @(posedge CLK or posedge RESET) begin
    logic [7:0] d1, d2;
    logic [2:0] op;
    bit wr;
    logic [31:0] npc;
    if (RESET) begin
      m_pc = 32'd0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    end else begin
      model_out(bus.INSTRUCTION, d1, d2, op, wr, npc);
      if (wr) m_regs[bus.INSTRUCTION[18:16]] = bus.ALURESULT;
      m_pc = npc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    logic [7:0] d1, d2;
    logic [2:0] op;
    bit wr;
    logic [31:0] npc;
    model_out(bus.INSTRUCTION, d1, d2, op, wr, npc);
    chk("pc",    bus.PC,    m_pc);
    chk("data1", 32'(bus.DATA1), 32'(d1));
    chk("data2", 32'(bus.DATA2), 32'(d2));
    chk("aluop", 32'(bus.ALUOP), 32'(op));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic issue(input logic [31:0] ins);
    logic [7:0] d1, d2;
    logic [2:0] op;
    bit wr;
    logic [31:0] npc;
    bus.INSTRUCTION = ins;
    model_out(ins, d1, d2, op, wr, npc);
    bus.ALURESULT = alu(d1, d2, op);
    $display("issue pc=%h ins=%h aluresult=%h", m_pc, ins, bus.ALURESULT);
  endtask

  // Reads a register through DATA1 with a mov, then restores the instruction.
  task automatic peek(input string nm, input logic [2:0] idx, input logic [7:0] exp);
    logic [31:0] saved;
    logic [31:0] probe;
    saved = bus.INSTRUCTION;
    probe = {8'h01, 8'h00, 5'b0, idx, 8'h00};
    bus.INSTRUCTION = probe;
    #0.5;
    chk(nm, 32'(bus.DATA1), 32'(exp));
    bus.INSTRUCTION = saved;
    #0.5;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  initial begin
    bus.INSTRUCTION = 32'h0003_002A;
    bus.ALURESULT   = 8'h2A;

    // loadi r3,0x2A right out of reset
    do_reset();
    issue(32'h0003_002A);
    #0.5;
    chk("lit_loadi_data2", 32'(bus.DATA2), 32'h2A);
    chk("lit_loadi_aluop", 32'(bus.ALUOP), 32'h0);
    chk("lit_loadi_pc0",   bus.PC, 32'h0);
    step();
    chk("lit_loadi_pc4", bus.PC, 32'h4);
    peek("lit_r3", 3'd3, 8'h2A);

    // sub r4,r1,r2 with r1=5, r2=3
    issue(32'h0001_0005); step();
    issue(32'h0002_0003); step();
    issue(32'h0304_0102);
    #0.5;
    chk("lit_sub_data1", 32'(bus.DATA1), 32'h05);
    chk("lit_sub_data2", 32'(bus.DATA2), 32'hFD);
    chk("lit_sub_aluop", 32'(bus.ALUOP), 32'h1);
    chk("lit_sub_alures", 32'(bus.ALURESULT), 32'h02);
    step();
    chk("lit_sub_pc", bus.PC, 32'h10);
    peek("lit_r4", 3'd4, 8'h02);

    // j backwards / forwards from PC=0x10
    issue(32'h06FE_0000); step();
    chk("lit_jback_pc", bus.PC, 32'h0C);
    issue(32'h0000_0099); step();          // loadi r0,0x99: r0 is an ordinary reg
    peek("lit_r0", 3'd0, 8'h99);
    issue(32'h0603_0000); step();
    chk("lit_jfwd_pc", bus.PC, 32'h20);
    peek("lit_r4_kept", 3'd4, 8'h02);

    // beq taken
    do_reset();
    issue(32'h0001_0007); step();
    issue(32'h0002_0007); step();
    issue(32'h0702_0102); step();
    chk("lit_beq_taken", bus.PC, 32'h14);

    // beq not taken
    do_reset();
    issue(32'h0001_0007); step();
    issue(32'h0002_0006); step();
    issue(32'h0702_0102); step();
    chk("lit_beq_nt", bus.PC, 32'h0C);

    // add r5,r5,r1: same-cycle read sees old r5
    issue(32'h0005_0010); step();
    issue(32'h0205_0501);
    #0.5;
    chk("lit_fwd_before", 32'(bus.DATA1), 32'h10);
    step();
    chk("lit_fwd_after", 32'(bus.DATA1), 32'h17);

    // j with offset -128 wraps below zero
    issue(32'h0680_0000); step();
    chk("lit_wrap_pc", bus.PC, 32'hFFFF_FE18);

    // and / or / unknown opcode
    issue(32'h0406_0102); step();
    peek("lit_and_r6", 3'd6, 8'h06);
    issue(32'h0507_0102); step();
    peek("lit_or_r7", 3'd7, 8'h07);
    issue(32'hFF07_0102); step();
    peek("lit_unk_r7", 3'd7, 8'h07);
    chk("lit_unk_pc", bus.PC, 32'hFFFF_FE24);

    // Mid-cycle reset with r3=0x2A, PC=0x40
    do_reset();
    issue(32'h0003_002A); step();
    issue(32'h060E_0000); step();
    chk("lit_pc40", bus.PC, 32'h40);
    issue(32'h0003_0055);
    #0.5;
    RESET = 1'b1;
    #0.5;
    chk("lit_rst_pc", bus.PC, 32'h0);
    peek("lit_rst_r3", 3'd3, 8'h00);
    step();                                 // edge while RESET held
    chk("lit_rst_hold_pc", bus.PC, 32'h0);
    peek("lit_rst_hold_r3", 3'd3, 8'h00);
    RESET = 1'b0;
    issue(32'h0003_0055); step();
    peek("lit_post_r3", 3'd3, 8'h55);
    chk("lit_post_pc", bus.PC, 32'h4);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
